rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter
//  Description : Round-robin arbiter sharing one 64K byte ROM between a CPU
//                port and a blitter port; fixed 4-cycle access.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        cpu_req_i,
    input  logic [15:0] cpu_address_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_data_o,
    input  logic        blt_req_i,
    input  logic [15:0] blt_address_i,
    output logic        blt_ack_o,
    output logic [7:0]  blt_data_o,
    output logic [15:0] rom_address_o,
    input  logic [7:0]  rom_data_i,
    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_BLT = 1'b1;

    logic [1:0]  state_q,       state_d;
    logic [15:0] rom_address_q, rom_address_d;
    logic        grant_id_q,    grant_id_d;
    logic        last_grant_q,  last_grant_d;
    logic [7:0]  cpu_data_q,    cpu_data_d;
    logic [7:0]  blt_data_q,    blt_data_d;

    logic        w_winner;
    logic        w_any_req;

    // On a tie the port that did not win last time gets the slot.
    always_comb begin
        w_any_req = cpu_req_i | blt_req_i;
        if (cpu_req_i && blt_req_i) begin
            w_winner = ~last_grant_q;
        end else if (blt_req_i) begin
            w_winner = GRANT_BLT;
        end else begin
            w_winner = GRANT_CPU;
        end
    end

    always_comb begin
        state_d       = state_q;
        rom_address_d = rom_address_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        cpu_data_d    = cpu_data_q;
        blt_data_d    = blt_data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    state_d       = ST_ISSUE;
                    grant_id_d    = w_winner;
                    last_grant_d  = w_winner;
                    rom_address_d = (w_winner == GRANT_BLT) ? blt_address_i : cpu_address_i;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_ACK;
                if (grant_id_q == GRANT_BLT) begin
                    blt_data_d = rom_data_i;
                end else begin
                    cpu_data_d = rom_data_i;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset also aborts any in-flight access: no ack and no capture follow.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            rom_address_q <= 16'h0000;
            grant_id_q    <= GRANT_CPU;
            last_grant_q  <= GRANT_BLT;
            cpu_data_q    <= 8'h00;
            blt_data_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            rom_address_q <= rom_address_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            cpu_data_q    <= cpu_data_d;
            blt_data_q    <= blt_data_d;
        end
    end

    assign cpu_ack_o     = (state_q == ST_ACK) && (grant_id_q == GRANT_CPU);
    assign blt_ack_o     = (state_q == ST_ACK) && (grant_id_q == GRANT_BLT);
    assign cpu_data_o    = cpu_data_q;
    assign blt_data_o    = blt_data_q;
    assign rom_address_o = rom_address_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
